// File: rtl/multi_debouncer_pkg.sv
// Shared types and helpers for the multi-channel button debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   deb_state_t    per-channel FSM state encoding
//   rpt_cnt_width  width of the auto-repeat counter for a given delay/period pair
package multi_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } deb_state_t;

    // Wide enough to hold the larger of the two repeat intervals.
    function automatic int rpt_cnt_width(input int delay, input int period);
        int longest;
        longest = (delay > period) ? delay : period;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, qualification FSM, stability counter, optional auto-repeat.
// Latency: press/release accepted SYNC_STAGES + 2^CNT_W edges after the raw input changes.
// Backpressure: none; pulses are single-cycle and are not held for a consumer.
//
// Ports:
//   global_clock   rising-edge clock
//   reset          asynchronous active-high reset
//   en             synchronous enable; low forces IDLE and zero outputs on the next edge
//   button_in      raw asynchronous button input
//   level          debounced level (registered)
//   level_d        value level takes on the next edge (feeds the top's any_pressed flop)
//   press_pulse    one-cycle pulse on accepted press (and on auto-repeat)
//   release_pulse  one-cycle pulse on accepted release
//
// Optional feature: AUTOREPEAT_EN adds a repeat counter that re-fires press_pulse while held.
module debounce_channel #(
    parameter int CNT_W         = 10,
    parameter int SYNC_STAGES   = 2
`ifdef AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
`endif
) (
    input  logic global_clock,
    input  logic reset,
    input  logic en,
    input  logic button_in,
    output logic level,
    output logic level_d,
    output logic press_pulse,
    output logic release_pulse
);

    import multi_debouncer_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_t             state;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_done;

    assign s        = sync_q[SYNC_STAGES-1];
    assign cnt_done = (cnt == CNT_MAX);

    // The synchroniser runs regardless of en so the sampled value is valid the moment en returns.
    always_ff @(posedge global_clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_in};
        end
    end

    // Next debounced level; the top ORs these so any_pressed lines up with button_level.
    always_comb begin
        level_d = 1'b0;
        if (en) begin
            case (state)
                PRESS_CHK: level_d = s && cnt_done;
                HELD:      level_d = 1'b1;
                REL_CHK:   level_d = s || !cnt_done;
                default:   level_d = 1'b0;
            endcase
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int             RPT_W       = rpt_cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;   // still waiting for the initial (longer) delay
    logic             rpt_fire;

    // Only cycles spent in HELD with the input still high count towards a repeat.
    assign rpt_fire = en && (state == HELD) && s &&
                      (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST));

    // Cleared while not yet accepted so entry to HELD from PRESS_CHK starts from zero;
    // REL_CHK neither clears nor advances, so a bounce back to HELD resumes the count.
    always_ff @(posedge global_clock or posedge reset) begin
        if (reset) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (!en || state == IDLE || state == PRESS_CHK) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state == HELD && s) begin
            if (rpt_fire) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge global_clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            level         <= level_d;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (s) begin
                            state <= PRESS_CHK;
                            cnt   <= '0;
                        end
                    end
                    PRESS_CHK: begin
                        if (!s) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt_done) begin
                            state       <= HELD;
                            cnt         <= '0;
                            press_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!s) begin
                            state <= REL_CHK;
                            cnt   <= '0;
                        end
`ifdef AUTOREPEAT_EN
                        else if (rpt_fire) begin
                            press_pulse <= 1'b1;
                        end
`endif
                    end
                    REL_CHK: begin
                        if (s) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt_done) begin
                            state         <= IDLE;
                            cnt           <= '0;
                            release_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel push-button debouncer: NUM_CH independent debounce_channel instances.
// Latency: SYNC_STAGES + 2^CNT_W edges from raw input change to pulse; any_pressed aligned with button_level.
// Backpressure: none; outputs are registered levels and single-cycle pulses.
//
// Ports:
//   global_clock   rising-edge clock
//   reset          asynchronous active-high reset
//   en             synchronous enable; low forces all channels idle and all outputs to 0
//   button_in      raw asynchronous button inputs, bit i = channel i
//   button_level   debounced level per channel
//   press_pulse    one-cycle pulse per accepted press (and per auto-repeat)
//   release_pulse  one-cycle pulse per accepted release
//   any_pressed    registered OR of all debounced levels
//
// Optional feature: define AUTOREPEAT_EN to enable press auto-repeat (REPEAT_DELAY / REPEAT_PERIOD).
module multi_debouncer #(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 10,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic              global_clock,
    input  logic              reset,
    input  logic              en,
    input  logic [NUM_CH-1:0] button_in,
    output logic [NUM_CH-1:0] button_level,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic              any_pressed
);

    import multi_debouncer_pkg::*;

    logic [NUM_CH-1:0] level_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .CNT_W        (CNT_W),
            .SYNC_STAGES  (SYNC_STAGES)
`ifdef AUTOREPEAT_EN
            ,
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
        ) u_ch (
            .global_clock (global_clock),
            .reset        (reset),
            .en           (en),
            .button_in    (button_in[i]),
            .level        (button_level[i]),
            .level_d      (level_d[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i])
        );
    end

    // Registered from the channels' next levels so it never lags button_level by a cycle.
    always_ff @(posedge global_clock or posedge reset) begin
        if (reset) begin
            any_pressed <= 1'b0;
        end else begin
            any_pressed <= |level_d;
        end
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: directed scenarios plus randomized stimulus.
// Reference model: run-length rule (level flips after 2^CNT_W+1 consecutive disagreeing edges).
// Optional feature: define AUTOREPEAT_EN to exercise and check auto-repeat.
module tb_multi_debouncer;

    localparam int NUM_CH        = 4;
    localparam int CNT_W         = 4;
    localparam int SYNC_STAGES   = 2;
    localparam int REPEAT_DELAY  = 40;
    localparam int REPEAT_PERIOD = 8;
    localparam int ACCEPT_EDGES  = (1 << CNT_W) + 1;
    localparam int PRESS_LAT     = SYNC_STAGES + (1 << CNT_W);

    logic              global_clock = 1'b0;
    logic              reset;
    logic              en;
    logic [NUM_CH-1:0] button_in;
    logic [NUM_CH-1:0] button_level;
    logic [NUM_CH-1:0] press_pulse;
    logic [NUM_CH-1:0] release_pulse;
    logic              any_pressed;

    multi_debouncer #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .SYNC_STAGES  (SYNC_STAGES),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) dut (
        .global_clock (global_clock),
        .reset        (reset),
        .en           (en),
        .button_in    (button_in),
        .button_level (button_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .any_pressed  (any_pressed)
    );

    always #5 global_clock = ~global_clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---------------- reference model ----------------
    logic [NUM_CH-1:0] hist[$];   // raw samples still travelling through the synchroniser
    logic [NUM_CH-1:0] m_lvl, m_pp, m_rp;
    int                m_run[NUM_CH];   // consecutive edges where synced input != level
    int                m_h[NUM_CH];     // edges spent held with input high since accept

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < SYNC_STAGES; k++) hist.push_back('0);
        m_lvl = '0;
        m_pp  = '0;
        m_rp  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_run[c] = 0;
            m_h[c]   = 0;
        end
    endtask

    task automatic model_edge();
        logic [NUM_CH-1:0] s_vec;
        s_vec = hist.pop_front();
        hist.push_back(button_in);
        m_pp = '0;
        m_rp = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!en) begin
                m_lvl[c] = 1'b0;
                m_run[c] = 0;
                m_h[c]   = 0;
            end else if (s_vec[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == ACCEPT_EDGES) begin
                    m_lvl[c] = s_vec[c];
                    m_run[c] = 0;
                    m_h[c]   = 0;
                    if (s_vec[c]) m_pp[c] = 1'b1;
                    else          m_rp[c] = 1'b1;
                end
            end else begin
                if (m_lvl[c] && m_run[c] == 0) begin
                    m_h[c]++;
`ifdef AUTOREPEAT_EN
                    if (m_h[c] == REPEAT_DELAY ||
                        (m_h[c] > REPEAT_DELAY && (m_h[c] - REPEAT_DELAY) % REPEAT_PERIOD == 0))
                        m_pp[c] = 1'b1;
`endif
                end
                m_run[c] = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("button_level",  int'(button_level),  int'(m_lvl));
        chk("press_pulse",   int'(press_pulse),   int'(m_pp));
        chk("release_pulse", int'(release_pulse), int'(m_rp));
        chk("any_pressed",   int'(any_pressed),   int'(|m_lvl));
    endtask

    task automatic tick();
        @(posedge global_clock);
        if (!reset) model_edge();
        @(negedge global_clock);
        check_outputs();
        cyc++;
    endtask

    // Directed observation: per-channel pulse counts and first indices over a window.
    int pcnt[NUM_CH], pfirst[NUM_CH], rcnt[NUM_CH], rfirst[NUM_CH];
    int plist0[$];

    task automatic watch(input int n);
        plist0.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            pcnt[c] = 0; pfirst[c] = -1; rcnt[c] = 0; rfirst[c] = -1;
        end
        for (int i = 0; i < n; i++) begin
            tick();
            for (int c = 0; c < NUM_CH; c++) begin
                if (press_pulse[c] === 1'b1) begin
                    if (pcnt[c] == 0) pfirst[c] = i;
                    pcnt[c]++;
                    if (c == 0) plist0.push_back(i);
                end
                if (release_pulse[c] === 1'b1) begin
                    if (rcnt[c] == 0) rfirst[c] = i;
                    rcnt[c]++;
                end
            end
        end
    endtask

    int bounce_p, pre_r;
    int exp_rpt[$];
    int flip_div;

    initial begin
        reset     = 1'b1;
        en        = 1'b1;
        button_in = '0;
        model_reset();
        watch(3);
        chk("reset_level", int'(button_level), 0);
        reset = 1'b0;
        watch(3);

        // Clean hold on ch0: pulse one cycle after edge SYNC_STAGES + 2^CNT_W.
        button_in = 4'b0001;
        watch(30);
        chk("ch0_press_count", pcnt[0], 1);
        chk("ch0_press_idx",   pfirst[0], PRESS_LAT);
        chk("ch0_level_held",  int'(button_level[0]), 1);
        chk("any_pressed_held", int'(any_pressed), 1);

        // Bounce on ch1 never reaches the stability threshold.
        bounce_p = 0;
        button_in[1] = 1'b1; watch(10); bounce_p += pcnt[1];
        button_in[1] = 1'b0; watch(1);  bounce_p += pcnt[1];
        button_in[1] = 1'b1; watch(10); bounce_p += pcnt[1];
        button_in[1] = 1'b0; watch(25); bounce_p += pcnt[1];
        chk("ch1_bounce_press", bounce_p, 0);
        chk("ch1_bounce_level", int'(button_level[1]), 0);

        // Release bounce on ch0: only the final steady low is accepted.
        pre_r = 0;
        button_in[0] = 1'b0; watch(5); pre_r += rcnt[0];
        button_in[0] = 1'b1; watch(1); pre_r += rcnt[0];
        chk("ch0_early_release", pre_r, 0);
        button_in[0] = 1'b0; watch(30);
        chk("ch0_release_count", rcnt[0], 1);
        chk("ch0_release_idx",   rfirst[0], PRESS_LAT);
        chk("ch0_level_released", int'(button_level[0]), 0);

        // Simultaneous press on ch2/ch3.
        button_in = 4'b1100;
        watch(20);
        chk("ch2_press_idx", pfirst[2], PRESS_LAT);
        chk("ch3_press_idx", pfirst[3], PRESS_LAT);
        chk("ch3_press_count", pcnt[3], 1);

        // en low: outputs clear on the next edge.
        en = 1'b0;
        watch(1);
        chk("en_off_level", int'(button_level), 0);
        chk("en_off_any",   int'(any_pressed), 0);
        watch(3);
        // en back: synchroniser already holds 1, so only the 2^CNT_W qualification remains.
        en = 1'b1;
        watch(20);
        chk("ch2_repress_idx",   pfirst[2], 1 << CNT_W);
        chk("ch3_repress_idx",   pfirst[3], 1 << CNT_W);
        chk("ch2_repress_count", pcnt[2], 1);

        button_in = '0;
        watch(25);

        // Long hold on ch0 (auto-repeat when enabled).
        button_in = 4'b0001;
        watch(PRESS_LAT + 79);
        exp_rpt.delete();
        exp_rpt.push_back(PRESS_LAT);
`ifdef AUTOREPEAT_EN
        for (int k = 0; k < 5; k++) exp_rpt.push_back(PRESS_LAT + REPEAT_DELAY + k * REPEAT_PERIOD);
`endif
        chk("ch0_long_press_count", plist0.size(), exp_rpt.size());
        for (int k = 0; k < exp_rpt.size(); k++)
            chk("ch0_long_press_idx", (k < plist0.size()) ? plist0[k] : -1, exp_rpt[k]);

        // Asynchronous reset while ch0 held: outputs clear before the next edge.
        reset = 1'b1;
        #1;
        chk("async_rst_level",   int'(button_level), 0);
        chk("async_rst_press",   int'(press_pulse), 0);
        chk("async_rst_release", int'(release_pulse), 0);
        chk("async_rst_any",     int'(any_pressed), 0);
        model_reset();
        watch(2);
        reset = 1'b0;
        // Still-held button is re-qualified from scratch.
        watch(25);
        chk("ch0_requal_idx",   pfirst[0], PRESS_LAT);
        chk("ch0_requal_count", pcnt[0], 1);

        // Randomized phase: alternating bouncy and stable blocks, occasional en drops.
        for (int blk = 0; blk < 16; blk++) begin
            flip_div = (blk % 2 == 0) ? 4 : 40;
            for (int i = 0; i < 200; i++) begin
                for (int c = 0; c < NUM_CH; c++)
                    if ($urandom_range(0, flip_div - 1) == 0) button_in[c] = ~button_in[c];
                en = ($urandom_range(0, 199) != 0);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
